wb_regfile: RTL and testbench



---
 rtl/wb_regfile.sv | 134 +++++++++++++
 tb/tb_wb_regfile.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//
// Write-back stage plus the 32 x 32-bit general-purpose register file of the
// five-stage pipeline.  The write-back value is chosen between the ALU result
// and the load data. It is committed to the register file on the rising edge.
// Two combinational read ports serve the ID stage. A write in flight is
// bypassed onto a read port that addresses the same register, so ID sees it in
// the same cycle.  A free-running counter records every committed write.
//
// Ports
//   clock   in   1   system clock, all state updates on the rising edge
//   reset   in   1   synchronous active-high reset (clears regs and counter)
//   wwreg   in   1   write-back enable from MEM/WB
//   wm2reg  in   1   1 = write load data (wdata), 0 = write ALU result (wr)
//   wrd     in   5   destination register index
//   wr      in  DW   ALU result from MEM/WB
//   wdata   in  DW   load data from MEM/WB
//   rna     in   5   read port A index
//   rnb     in   5   read port B index
//   qa      out DW   read port A data (write-first bypass)
//   qb      out DW   read port B data (write-first bypass)
//   wres    out DW   selected write-back value, also fed to forwarding muxes
//   wcount  out 32   number of committed writes to registers r1..r31
// -----------------------------------------------------------------------------
module wb_regfile #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wwreg,
    input  logic          wm2reg,
    input  logic [4:0]    wrd,
    input  logic [DW-1:0] wr,
    input  logic [DW-1:0] wdata,
    input  logic [4:0]    rna,
    input  logic [4:0]    rnb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    output logic [DW-1:0] wres,
    output logic [31:0]   wcount
);

    localparam int AW = 5;

    // Register storage.  Entry 0 exists only to keep indexing simple; it is
    // held at zero and never read, since index 0 is decoded to a constant.
    logic [DW-1:0]   regs_reg [NREG];
    logic [31:0]     wcount_reg;
    logic [31:0]     wcount_next;

    logic            we_eff;
    logic [NREG-1:0] wsel;

    // -------------------------------------------------------------------------
    // Write-back select and commit qualification
    // -------------------------------------------------------------------------
    assign wres = wm2reg ? wdata : wr;

    // Reset suppresses the commit so a write presented alongside reset is
    // dropped, neither stored nor counted, and also not bypassed to the reads.
    assign we_eff = wwreg & (wrd != '0) & ~reset;

    // One-hot write select per register.  Bit 0 is tied low so r0 can never
    // be written.
    assign wsel[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_wsel
            assign wsel[gi] = we_eff && (wrd == AW'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Register storage
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wsel[i]) begin
                    regs_reg[i] <= wres;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Committed-write counter.  It wraps silently at the top of its range.
    // -------------------------------------------------------------------------
    always_comb begin
        wcount_next = wcount_reg;
        if (we_eff) begin
            wcount_next = wcount_reg + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wcount_reg <= '0;
        end else begin
            wcount_reg <= wcount_next;
        end
    end

    assign wcount = wcount_reg;

    // -------------------------------------------------------------------------
    // Read ports.  Index 0 returns zero. This takes priority over the bypass,
    // although we_eff is already low for wrd == 0.  Otherwise a same-cycle
    // commit to the addressed register is returned ahead of the stored value.
    // -------------------------------------------------------------------------
    function automatic logic [DW-1:0] read_port(input logic [AW-1:0] idx);
        logic [DW-1:0] val;
        val = '0;
        if (idx == '0) begin
            val = '0;
        end else if (we_eff && (wrd == idx)) begin
            val = wres;
        end else begin
            val = regs_reg[idx];
        end
        return val;
    endfunction

    always_comb begin
        qa = read_port(rna);
        qb = read_port(rnb);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//
// Self-checking bench for wb_regfile.  The bench drives inputs at the falling
// edge and samples outputs 1 ns later. It applies the following stimulus:
//   * a table of directed vectors with constant expected values,
//   * hand-written sequences for full reset and counter wrap,
//   * randomized traffic compared against a behavioural register-file model.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

    logic        clock;
    logic        reset;
    logic        wwreg;
    logic        wm2reg;
    logic [4:0]  wrd;
    logic [31:0] wr;
    logic [31:0] wdata;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] wres;
    logic [31:0] wcount;

    int unsigned n_total;
    int unsigned n_pass;

    // Behavioural model: architectural register contents and commit count.
    logic [31:0] m_regs [32];
    logic [31:0] m_count;

    wb_regfile #(.NREG(32), .DW(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .wwreg  (wwreg),
        .wm2reg (wm2reg),
        .wrd    (wrd),
        .wr     (wr),
        .wdata  (wdata),
        .rna    (rna),
        .rnb    (rnb),
        .qa     (qa),
        .qb     (qb),
        .wres   (wres),
        .wcount (wcount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        ww;
        logic        m2r;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] exp_qa;
        logic [31:0] exp_qb;
        logic [31:0] exp_wres;
        logic [31:0] exp_wcount;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic ww, input logic m2r, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] ld,
                         input logic [4:0] ra, input logic [4:0] rb);
        reset  = r;
        wwreg  = ww;
        wm2reg = m2r;
        wrd    = rd;
        wr     = alu;
        wdata  = ld;
        rna    = ra;
        rnb    = rb;
    endtask

    // Model reaction to a rising edge, derived from the current inputs.
    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_count = '0;
        end else if (wwreg && wrd != 0) begin
            m_regs[wrd] = wm2reg ? wdata : wr;
            m_count     = m_count + 32'd1;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        logic [31:0] sel;
        sel = wm2reg ? wdata : wr;
        if (idx == 0) return 32'd0;
        if (!reset && wwreg && wrd == idx) return sel;
        return m_regs[idx];
    endfunction

    // One clock: drive at negedge, check against model at negedge+1, then edge.
    task automatic model_cycle(input string tag);
        #1;
        check({tag, ".qa"},     qa,     model_read(rna));
        check({tag, ".qb"},     qb,     model_read(rnb));
        check({tag, ".wres"},   wres,   wm2reg ? wdata : wr);
        check({tag, ".wcount"}, wcount, m_count);
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        m_count = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 5'd3, 32'h1234_5678, 32'hAAAA_AAAA, 5'd3, 5'd0, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 5'd4, 32'h0, 32'hAAAA_AAAA, 5'd3, 5'd4, 32'h1234_5678, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'd1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd3, 32'hAAAA_AAAA, 32'h1234_5678, 32'h0, 32'd2};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 5'd7, 32'h11, 32'h0, 5'd7, 5'd7, 32'h11, 32'h11, 32'h11, 32'd2};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 5'd7, 32'h22, 32'h0, 5'd7, 5'd7, 32'h22, 32'h22, 32'h22, 32'd3};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7, 32'h22, 32'h22, 32'h0, 32'd4};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd7, 32'h0, 32'h22, 32'hFFFF_FFFF, 32'd4};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'd4};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 5'd9, 32'h99, 32'h0, 5'd9, 5'd0, 32'h99, 32'h0, 32'h99, 32'd4};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 5'd9, 32'h55, 32'h0, 5'd9, 5'd9, 32'h99, 32'h99, 32'h55, 32'd5};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9, 32'h99, 32'h99, 32'h0, 32'd5};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 5'd5, 32'h5555, 32'h0, 5'd5, 5'd0, 32'h5555, 32'h0, 32'h5555, 32'd5};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0, 5'd5, 5'd9, 32'h5555, 32'h99, 32'hDEAD_BEEF, 32'd6};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd9, 32'h0, 32'h0, 32'h0, 32'd0};

        // Power-on reset.
        apply(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        apply(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd31);
        #1;
        check("reset.qa", qa, 32'h0);
        check("reset.qb", qb, 32'h0);
        check("reset.wcount", wcount, 32'h0);
        @(negedge clock);

        // Directed vectors. The model is updated at each edge and stays in step.
        for (int v = 0; v < 14; v++) begin
            apply(vecs[v].rst, vecs[v].ww, vecs[v].m2r, vecs[v].rd, vecs[v].alu,
                  vecs[v].ld, vecs[v].ra, vecs[v].rb);
            #1;
            check($sformatf("vec%0d.qa", v),     qa,     vecs[v].exp_qa);
            check($sformatf("vec%0d.qb", v),     qb,     vecs[v].exp_qb);
            check($sformatf("vec%0d.wres", v),   wres,   vecs[v].exp_wres);
            check($sformatf("vec%0d.wcount", v), wcount, vecs[v].exp_wcount);
            @(posedge clock);
            model_edge();
            @(negedge clock);
        end

        // Fill every register with a nonzero value.
        for (int i = 1; i < 32; i++) begin
            apply(1'b0, 1'b1, i[0], 5'(i), 32'h0101_0101 * i, 32'hF0F0_0000 | i, 5'(i), 5'(32 - i));
            model_cycle($sformatf("fill%0d", i));
        end
        // Apply reset while a write to r5 is pending. The write must be lost.
        apply(1'b1, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0, 5'd5, 5'd6);
        model_cycle("rst_mid");
        for (int i = 0; i < 32; i++) begin
            apply(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
            #1;
            check($sformatf("clr%0d.qa", i), qa, 32'h0);
            check($sformatf("clr%0d.qb", i), qb, 32'h0);
            check($sformatf("clr%0d.wcount", i), wcount, 32'h0);
            @(negedge clock);
        end
        // The first edge after reset commits.
        apply(1'b0, 1'b1, 1'b0, 5'd5, 32'hCAFE_0005, 32'h0, 5'd5, 5'd5);
        model_cycle("post_rst");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] rd;
            rd = 5'($urandom_range(0, 31));
            apply(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                  rd, $urandom, $urandom,
                  ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)));
            model_cycle($sformatf("rnd%0d", n));
        end

        // Counter wrap: preload the counter, then issue commits across the wrap.
        force dut.wcount_reg = 32'hFFFF_FFFE;
        #1;
        release dut.wcount_reg;
        m_count = 32'hFFFF_FFFE;
        apply(1'b0, 1'b1, 1'b0, 5'd12, 32'h1, 32'h0, 5'd12, 5'd0);
        model_cycle("wrap0");
        apply(1'b0, 1'b1, 1'b0, 5'd13, 32'h2, 32'h0, 5'd12, 5'd13);
        model_cycle("wrap1");
        apply(1'b0, 1'b1, 1'b0, 5'd0, 32'h3, 32'h0, 5'd13, 5'd0);
        model_cycle("wrap2");
        #1;
        check("wrap.final", wcount, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
